// File: rtl/fifo_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_pkg
//  Description : Shared types and constants for the FIFO read skid buffer:
//                occupancy state encoding and the word-counter width.
//  Revision    : 1.0 - initial release
// ============================================================================
package fifo_pkg;

  // Width of the accepted-transfer statistics counter.
  localparam int COUNT_W = 16;

  // Skid buffer occupancy, encoded directly as the number of held words.
  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_TWO   = 2'd2
  } occ_e;

  // Numeric word count held in a given occupancy state.
  function automatic logic [1:0] occ_level(input occ_e s);
    return s;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_rd_skid_buf.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_rd_skid_buf
//  Description : Two-entry in-order register store with head/tail pointers.
//                Fullness is owned by the caller; a push is only issued when
//                a slot is free or the head slot is popped on the same edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module fifo_rd_skid_buf #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [2];
  logic             head;
  logic             tail;

  // Write at tail, retire at head; with both pointers equal (full) a
  // simultaneous push+pop overwrites the slot being retired, which keeps
  // the surviving word ahead of the new one.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem[0] <= '0;
      mem[1] <= '0;
      head   <= 1'b0;
      tail   <= 1'b0;
    end else begin
      if (push) begin
        mem[tail] <= wr_data;
        tail      <= ~tail;
      end
      if (pop) begin
        head <= ~head;
      end
    end
  end

  assign rd_data = mem[head];

endmodule
`default_nettype wire

// File: rtl/fifo_rd_skid.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_rd_skid
//  Description : Converts a one-cycle-latency FIFO read port (rd_en -> dv)
//                into a valid/ready stream using a 2-entry skid buffer and
//                credit-based read issue. Flags stray read data as overrun.
//  Options     : FIFO_RD_SKID_STATS_EN - enables the 16-bit accepted-transfer
//                counter on o_Word_Count (otherwise tied to zero).
//  Revision    : 1.0 - initial release
// ============================================================================
module fifo_rd_skid
  import fifo_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               i_Clk,
  input  logic               i_Rst,
  input  logic               i_Empty,
  output logic               o_Rd_En,
  input  logic               i_Rd_DV,
  input  logic [WIDTH-1:0]   i_Rd_Data,
  output logic               o_Valid,
  input  logic               i_Ready,
  output logic [WIDTH-1:0]   o_Data,
  output logic               o_Overrun,
  output logic [COUNT_W-1:0] o_Word_Count
);

  occ_e       occ;
  occ_e       occ_nx;
  logic       inflight;
  logic       overrun;
  logic       pop;
  logic       dv_ok;
  logic       push;
  logic [2:0] credit_used;

  // Output side handshake; valid is forced low while reset is applied.
  assign o_Valid = (occ != OCC_EMPTY) & ~i_Rst;
  assign pop     = o_Valid & i_Ready;

  // Only read data that answers an issued read is stored.
  assign dv_ok = i_Rd_DV & inflight;
  assign push  = dv_ok & ((occ != OCC_TWO) | pop);

  // Credit: words held plus words in flight, less the one leaving now,
  // must stay below two for another read to be issued.
  assign credit_used = {1'b0, occ_level(occ)} + {2'b00, inflight};
  assign o_Rd_En     = ~i_Empty & ~i_Rst & (credit_used < (3'd2 + {2'b00, pop}));

  // Occupancy state register.
  always_ff @(posedge i_Clk) begin
    if (i_Rst) occ <= OCC_EMPTY;
    else       occ <= occ_nx;
  end

  // Occupancy next-state: +1 on stored read data, -1 on downstream pop.
  always_comb begin
    occ_nx = occ;
    case (occ)
      OCC_EMPTY: if (push)              occ_nx = OCC_ONE;
      OCC_ONE: begin
        if (push && !pop)               occ_nx = OCC_TWO;
        else if (pop && !push)          occ_nx = OCC_EMPTY;
      end
      OCC_TWO:   if (pop && !push)      occ_nx = OCC_ONE;
      default:                          occ_nx = OCC_EMPTY;
    endcase
  end

  // Read-in-flight tracking: set by an issued read, cleared by its data.
  always_ff @(posedge i_Clk) begin
    if (i_Rst) inflight <= 1'b0;
    else       inflight <= o_Rd_En | (inflight & ~i_Rd_DV);
  end

  // Sticky overrun: read data arrived with no read outstanding.
  always_ff @(posedge i_Clk) begin
    if (i_Rst)                      overrun <= 1'b0;
    else if (i_Rd_DV && !inflight)  overrun <= 1'b1;
  end

  assign o_Overrun = overrun;

  fifo_rd_skid_buf #(
    .WIDTH (WIDTH)
  ) u_buf (
    .clk     (i_Clk),
    .rst     (i_Rst),
    .push    (push),
    .wr_data (i_Rd_Data),
    .pop     (pop),
    .rd_data (o_Data)
  );

`ifdef FIFO_RD_SKID_STATS_EN
  logic [COUNT_W-1:0] word_count;

  // Accepted-transfer counter, wraps naturally at its width.
  always_ff @(posedge i_Clk) begin
    if (i_Rst)    word_count <= '0;
    else if (pop) word_count <= word_count + 1'b1;
  end

  assign o_Word_Count = word_count;
`else
  assign o_Word_Count = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fifo_rd_skid.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fifo_rd_skid
//  Description : Self-checking bench for fifo_rd_skid with an upstream FIFO
//                model, a scoreboard queue and a cycle-level monitor.
//  Options     : FIFO_RD_SKID_STATS_EN - also exercises counter wrap.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_rd_skid;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             i_Rst = 1'b1;
  logic             i_Empty = 1'b1;
  logic             o_Rd_En;
  logic             i_Rd_DV = 1'b0;
  logic [WIDTH-1:0] i_Rd_Data = '0;
  logic             o_Valid;
  logic             i_Ready = 1'b0;
  logic [WIDTH-1:0] o_Data;
  logic             o_Overrun;
  logic [15:0]      o_Word_Count;

  fifo_rd_skid #(.WIDTH(WIDTH)) dut (
    .i_Clk        (clk),
    .i_Rst        (i_Rst),
    .i_Empty      (i_Empty),
    .o_Rd_En      (o_Rd_En),
    .i_Rd_DV      (i_Rd_DV),
    .i_Rd_Data    (i_Rd_Data),
    .o_Valid      (o_Valid),
    .i_Ready      (i_Ready),
    .o_Data       (o_Data),
    .o_Overrun    (o_Overrun),
    .o_Word_Count (o_Word_Count)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  logic [WIDTH-1:0] upq[$];     // upstream FIFO contents
  logic [WIDTH-1:0] exp_q[$];   // scoreboard: words expected downstream
  int               rd_log[$];  // cycles with o_Rd_En
  int               pop_log[$]; // cycles with a downstream transfer

  logic             rst_nx = 1'b1;
  logic             ready_nx = 1'b0;
  logic             pend_dv = 1'b0;
  logic [WIDTH-1:0] pend_data = '0;
  logic             force_dv = 1'b0;
  logic [WIDTH-1:0] force_data = '0;
  logic             mon_en = 1'b0;
  logic             done = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: cycle %0d got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // One clock cycle: apply inputs at negedge, then act as the upstream FIFO.
  task automatic step();
    @(negedge clk);
    i_Rst     = rst_nx;
    i_Ready   = ready_nx;
    i_Empty   = (upq.size() == 0);
    i_Rd_DV   = pend_dv | force_dv;
    i_Rd_Data = force_dv ? force_data : pend_data;
    force_dv  = 1'b0;
    #1;
    chk("rd_en_while_empty", 32'(o_Rd_En & i_Empty), 32'd0);
    chk("rd_en_in_reset", 32'(o_Rd_En & i_Rst), 32'd0);
    if (o_Rd_En && upq.size() != 0) begin
      pend_dv   = 1'b1;
      pend_data = upq.pop_front();
      rd_log.push_back(cyc);
    end else begin
      pend_dv = 1'b0;
    end
    cyc++;
  endtask

  task automatic load(input logic [WIDTH-1:0] w);
    upq.push_back(w);
    exp_q.push_back(w);
  endtask

  task automatic drain(input int bound);
    int n = 0;
    while (exp_q.size() != 0 && n < bound) begin
      step();
      n++;
    end
    if (exp_q.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL drain_timeout: %0d words left expected 0", exp_q.size());
    end
    step();
    step();
  endtask

  // Monitor: behavioural model of stream occupancy, overrun and count,
  // plus scoreboard comparison on every downstream transfer.
  int          m_occ = 0;
  logic        m_inf = 1'b0;
  logic        m_ovr = 1'b0;
  logic [15:0] m_cnt = '0;

  initial begin
    logic p;
    forever begin
      @(negedge clk);
      #2;
      if (done) break;
      if (mon_en) begin
        chk("valid", 32'(o_Valid), 32'((m_occ > 0) && !i_Rst));
        chk("overrun", 32'(o_Overrun), 32'(m_ovr));
`ifdef FIFO_RD_SKID_STATS_EN
        chk("word_count", 32'(o_Word_Count), 32'(m_cnt));
`else
        chk("word_count_off", 32'(o_Word_Count), 32'd0);
`endif
        p = o_Valid & i_Ready;
        if (p) begin
          pop_log.push_back(cyc - 1);
          if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_word: got %0h expected none", o_Data);
          end else begin
            chk("data", 32'(o_Data), 32'(exp_q.pop_front()));
          end
        end
        if (i_Rst) begin
          m_occ = 0; m_inf = 1'b0; m_ovr = 1'b0; m_cnt = '0;
        end else begin
          if (i_Rd_DV && !m_inf) m_ovr = 1'b1;
          m_occ = m_occ + ((i_Rd_DV && m_inf) ? 1 : 0) - (p ? 1 : 0);
          if (m_occ > 2) begin
            tests++;
            fails++;
            $display("FAIL occupancy: got %0d expected at most 2", m_occ);
          end
          m_inf = o_Rd_En;
          if (p) m_cnt = m_cnt + 16'd1;
        end
      end
    end
  end

  initial begin
    logic [WIDTH-1:0] w0;
    // Reset state
    rst_nx = 1'b1;
    repeat (3) step();
    chk("rst_valid", 32'(o_Valid), 32'd0);
    chk("rst_rd_en", 32'(o_Rd_En), 32'd0);
    chk("rst_overrun", 32'(o_Overrun), 32'd0);
    chk("rst_data", 32'(o_Data), 32'd0);
    chk("rst_count", 32'(o_Word_Count), 32'd0);
    mon_en = 1'b1;
    rst_nx = 1'b0;
    step();

    // Four words streamed with ready high: back-to-back, latency 2
    rd_log.delete(); pop_log.delete();
    ready_nx = 1'b1;
    load(8'h11); load(8'h22); load(8'h33); load(8'h44);
    drain(30);
    chk("stream_reads", 32'(rd_log.size()), 32'd4);
    chk("stream_pops", 32'(pop_log.size()), 32'd4);
    if (rd_log.size() == 4 && pop_log.size() == 4) begin
      chk("stream_rd_span", 32'(rd_log[3] - rd_log[0]), 32'd3);
      chk("stream_latency", 32'(pop_log[0] - rd_log[0]), 32'd2);
      chk("stream_pop_span", 32'(pop_log[3] - pop_log[0]), 32'd3);
    end

    // Backpressure: only two reads, head word held stable
    rd_log.delete();
    ready_nx = 1'b0;
    w0 = 8'h5C;
    load(w0);
    for (int i = 1; i < 5; i++) load(WIDTH'($urandom));
    for (int i = 0; i < 8; i++) begin
      step();
      if (o_Valid) chk("hold_data", 32'(o_Data), 32'(w0));
    end
    chk("bp_reads", 32'(rd_log.size()), 32'd2);
    chk("bp_valid", 32'(o_Valid), 32'd1);
    ready_nx = 1'b1;
    drain(40);
    chk("bp_total_reads", 32'(rd_log.size()), 32'd5);

    // Toggling ready, eight words
    for (int i = 0; i < 8; i++) load(WIDTH'($urandom));
    for (int n = 0; n < 80 && exp_q.size() != 0; n++) begin
      ready_nx = ~ready_nx;
      step();
    end
    ready_nx = 1'b1;
    drain(20);
    chk("toggle_overrun", 32'(o_Overrun), 32'd0);

    // Random traffic with random backpressure and upstream gaps
    for (int n = 0; n < 400; n++) begin
      ready_nx = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 2) == 0) load(WIDTH'($urandom));
      step();
    end
    ready_nx = 1'b1;
    drain(1200);
    chk("random_overrun", 32'(o_Overrun), 32'd0);

    // Stray read data: sticky overrun, word discarded
    force_dv   = 1'b1;
    force_data = 8'hEE;
    step();
    for (int i = 0; i < 5; i++) begin
      step();
      chk("ovr_sticky", 32'(o_Overrun), 32'd1);
      chk("ovr_discard", 32'(o_Valid), 32'd0);
    end
    rst_nx = 1'b1;
    step();
    rst_nx = 1'b0;
    step();
    chk("ovr_cleared", 32'(o_Overrun), 32'd0);

    // Reset while a read is in flight: returning word dropped silently
    rd_log.delete();
    ready_nx = 1'b0;
    load(8'h5A);
    step();
    chk("midrst_read", 32'(rd_log.size()), 32'd1);
    rst_nx = 1'b1;
    step();
    upq.delete();
    exp_q.delete();
    rst_nx = 1'b0;
    step();
    step();
    chk("midrst_valid", 32'(o_Valid), 32'd0);
    chk("midrst_overrun", 32'(o_Overrun), 32'd0);
    ready_nx = 1'b1;

`ifdef FIFO_RD_SKID_STATS_EN
    // 65537 transfers wrap the counter to 1
    for (int i = 0; i < 65537; i++) load(WIDTH'(i));
    drain(66000);
    chk("count_wrap", 32'(o_Word_Count), 32'd1);
`else
    for (int i = 0; i < 6; i++) load(WIDTH'($urandom));
    drain(30);
    chk("count_off_final", 32'(o_Word_Count), 32'd0);
`endif

    done = 1'b1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Global time bound
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/fifo_rd_skid.md
FIFO_RD_SKID -- requirements
Module: fifo_rd_skid

Interface
REQ-001 SHALL have parameter WIDTH, default 8, data word width in bits.
REQ-002 SHALL have port i_Clk  input  1  single clock; all logic on rising edge.
REQ-003 SHALL have port i_Rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port i_Empty  input  1  upstream FIFO empty flag; must not depend combinationally on o_Rd_En.
REQ-005 SHALL have port o_Rd_En  output  1  read strobe to upstream FIFO.
REQ-006 SHALL have port i_Rd_DV  input  1  upstream read-data valid, exactly 1 cycle after accepted o_Rd_En.
REQ-007 SHALL have port i_Rd_Data  input  WIDTH  upstream read data, qualified by i_Rd_DV.
REQ-008 SHALL have port o_Valid  output  1  downstream stream word available.
REQ-009 SHALL have port i_Ready  input  1  downstream accepts word when o_Valid & i_Ready.
REQ-010 SHALL have port o_Data  output  WIDTH  downstream stream word, head of buffer.
REQ-011 SHALL have port o_Overrun  output  1  sticky error: i_Rd_DV with no read in flight.
REQ-012 SHALL have port o_Word_Count  output  16  accepted-transfer counter (see Configuration).

Function
REQ-013 SHALL hold a 2-entry in-order buffer; occupancy states EMPTY(0), ONE(1), TWO(2).
REQ-014 SHALL track r_Inflight (1 bit): set on o_Rd_En, cleared on i_Rd_DV the following cycle.
REQ-015 SHALL define pop = o_Valid & i_Ready; o_Valid = (occupancy != 0).
REQ-016 SHALL assert o_Rd_En = ~i_Empty & ~i_Rst & (occupancy + r_Inflight - pop < 2); combinational path i_Ready -> o_Rd_En permitted.
REQ-017 SHALL update occupancy_next = occupancy + i_Rd_DV - pop; EMPTY->ONE on DV only, ONE->TWO on DV without pop, TWO->ONE on pop without DV, ONE->EMPTY on pop without DV, hold on DV+pop or neither.
REQ-018 SHALL never exceed occupancy 2; credit rule in REQ-016 guarantees it.
REQ-019 SHALL on DV+pop in state TWO... unreachable by credit; if it occurs, behave as REQ-017 with data order preserved.
REQ-020 SHALL present i_Rd_Data on o_Data with o_Valid high on the cycle after i_Rd_DV (read issue N, DV N+1, o_Valid N+2).
REQ-021 SHALL hold o_Data stable while o_Valid & ~i_Ready.
REQ-022 SHALL sustain one word per cycle with i_Ready held high and i_Empty low.
REQ-023 SHALL set o_Overrun when i_Rd_DV=1 and r_Inflight=0; cleared only by reset; offending word discarded.
REQ-024 SHALL never assert o_Rd_En while i_Empty=1.

Reset
REQ-025 SHALL on i_Rst=1 at a clock edge: occupancy EMPTY, r_Inflight 0, o_Overrun 0, o_Word_Count 0, o_Data 0.
REQ-026 SHALL drive o_Rd_En 0 and o_Valid 0 during reset; in-flight word returning after mid-operation reset is discarded without setting o_Overrun.

Configuration
REQ-027 SHALL with FIFO_RD_SKID_STATS_EN defined, increment o_Word_Count on every pop, wrapping 0xFFFF->0.
REQ-028 SHALL without FIFO_RD_SKID_STATS_EN, drive o_Word_Count constant 0 and infer no counter flops.

Structure
REQ-029 SHALL place occupancy state encoding (EMPTY/ONE/TWO, 2-bit) and COUNT_W=16 in shared package fifo_pkg.
REQ-030 SHALL implement storage in one sub-module fifo_rd_skid_buf (2-entry register array, head/tail pointers); control in top.

Verification
REQ-031 SHALL cover: FIFO holds 4 words 0x11..0x44, i_Ready=1 -> o_Rd_En 4 consecutive cycles, o_Data 0x11..0x44 on 4 consecutive cycles starting 2 cycles after first read.
REQ-032 SHALL cover: i_Ready=0, FIFO holds 5 words -> exactly 2 reads issued, occupancy TWO, o_Data=first word stable; release i_Ready -> remaining 3 words delivered in order, no loss.
REQ-033 SHALL cover: i_Ready toggling 1010..., 8 words -> all 8 delivered in order, o_Overrun stays 0.
REQ-034 SHALL cover: i_Rd_DV pulse with no prior o_Rd_En -> o_Overrun=1 next cycle, stays 1 until i_Rst.
REQ-035 SHALL cover: i_Rst asserted cycle after o_Rd_En -> returning i_Rd_DV ignored, o_Valid=0, o_Overrun=0.
REQ-036 SHALL cover: with FIFO_RD_SKID_STATS_EN, 65537 transfers -> o_Word_Count=1; without macro -> o_Word_Count=0 throughout.
